// File: rtl/grid_io_bank_cfg.sv
// I/O grid tile with a memory-bank configuration row writer.
// Shadowed direction/invert rows steer each subtile's GPIO pad.
module grid_io_bank_cfg #(
    parameter int NUM_SUBTILES = 8,
    parameter int CFG_ROWS     = 2,
    parameter int ROW_W        = 1,
    parameter int SETUP_CYC    = 1,
    parameter int WL_PULSE     = 2
) (
    input  logic                    prog_clk,
    input  logic                    pReset_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [ROW_W-1:0]        cfg_row,
    input  logic [NUM_SUBTILES-1:0] cfg_data,
    input  logic                    cfg_last,
    output logic                    cfg_done,
    output logic                    cfg_err,
    output logic [NUM_SUBTILES-1:0] bl,
    output logic [CFG_ROWS-1:0]     wl,
    inout  wire  [NUM_SUBTILES-1:0] gfpga_pad_GPIO_PAD,
    input  logic [NUM_SUBTILES-1:0] outpad,
    output logic [NUM_SUBTILES-1:0] inpad
);

    localparam int MAX_C = (SETUP_CYC > WL_PULSE) ? SETUP_CYC : WL_PULSE;
    localparam int CNT_W = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_n;
    logic                    armed;
    logic [ROW_W-1:0]        row_q;
    logic [NUM_SUBTILES-1:0] data_q;
    logic                    last_q;
    logic [NUM_SUBTILES-1:0] shadow [CFG_ROWS];
    logic                    xfer;
    logic                    row_ok;

    // armed keeps ready low through reset and until the first edge after it
    assign cfg_ready = armed && (state == IDLE);
    assign cfg_done  = (state == DONE);
    assign xfer      = cfg_valid && cfg_ready;
    assign row_ok    = 32'(cfg_row) < CFG_ROWS;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (xfer) begin
                    if (row_ok) begin
                        state_n = SETUP;
                        cnt_n   = '0;
                    end else if (cfg_last) begin
                        state_n = DONE;
                    end
                end
            end
            SETUP: begin
                if (cnt == CNT_W'(SETUP_CYC - 1)) begin
                    state_n = PULSE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt == CNT_W'(WL_PULSE - 1)) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            HOLD:    state_n = last_q ? DONE : IDLE;
            DONE:    state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            armed  <= 1'b0;
            row_q  <= '0;
            data_q <= '0;
            last_q <= 1'b0;
            bl     <= '0;
            cfg_err <= 1'b0;
            for (int r = 0; r < CFG_ROWS; r++) shadow[r] <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            armed <= 1'b1;
            if (xfer) begin
                row_q  <= cfg_row;
                data_q <= cfg_data;
                last_q <= cfg_last;
                if (row_ok) bl <= cfg_data;
                else cfg_err <= 1'b1;
            end else if (state == HOLD) begin
                bl <= '0;
            end
            if (state == PULSE && cnt == '0) begin
                for (int r = 0; r < CFG_ROWS; r++)
                    if (row_q == ROW_W'(r)) shadow[r] <= data_q;
            end
        end
    end

    always_comb begin
        wl = '0;
        for (int r = 0; r < CFG_ROWS; r++)
            wl[r] = (state == PULSE) && (row_q == ROW_W'(r));
    end

    logic [NUM_SUBTILES-1:0] dir;
    logic [NUM_SUBTILES-1:0] inv;

    assign dir = shadow[0];

    if (CFG_ROWS > 1) begin : g_inv
        assign inv = shadow[1];
    end else begin : g_noinv
        assign inv = '0;
    end

    for (genvar i = 0; i < NUM_SUBTILES; i++) begin : g_pad
        assign gfpga_pad_GPIO_PAD[i] = dir[i] ? (outpad[i] ^ inv[i]) : 1'bz;
    end

    assign inpad = ~dir & gfpga_pad_GPIO_PAD;

endmodule

// File: tb/tb_grid_io_bank_cfg.sv
// Bench for grid_io_bank_cfg: a default tile and a slow 3-row tile
// checked each cycle against a transaction-timeline model.
module tb_grid_io_bank_cfg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int S[2] = '{1, 3};
    int P[2] = '{2, 4};
    int R[2] = '{2, 3};

    logic       valid [2];
    logic [1:0] row   [2];
    logic [7:0] data  [2];
    logic       last  [2];

    logic [7:0] outpad0, outpad1, tb_val;
    logic       ready0, done0, err0, ready1, done1, err1;
    logic [7:0] bl0, bl1, inpad0, inpad1;
    logic [1:0] wl0;
    logic [2:0] wl1;
    wire  [7:0] pad0, pad1;
    logic [7:0] tb_en;

    bit         armed [2];
    bit         act   [2];
    bit         mdone [2];
    bit         merr  [2];
    int         k     [2];
    int         mr    [2];
    logic [7:0] md    [2];
    bit         ml    [2];
    logic [7:0] msh   [2][4];

    assign tb_en = ~msh[0][0];
    for (genvar i = 0; i < 8; i++) begin : g_drv
        assign pad0[i] = tb_en[i] ? tb_val[i] : 1'bz;
    end

    grid_io_bank_cfg dut0 (
        .prog_clk(clk), .pReset_n(rst_n),
        .cfg_valid(valid[0]), .cfg_ready(ready0),
        .cfg_row(row[0][0:0]), .cfg_data(data[0]), .cfg_last(last[0]),
        .cfg_done(done0), .cfg_err(err0), .bl(bl0), .wl(wl0),
        .gfpga_pad_GPIO_PAD(pad0), .outpad(outpad0), .inpad(inpad0)
    );

    grid_io_bank_cfg #(
        .NUM_SUBTILES(8), .CFG_ROWS(3), .ROW_W(2),
        .SETUP_CYC(3), .WL_PULSE(4)
    ) dut1 (
        .prog_clk(clk), .pReset_n(rst_n),
        .cfg_valid(valid[1]), .cfg_ready(ready1),
        .cfg_row(row[1]), .cfg_data(data[1]), .cfg_last(last[1]),
        .cfg_done(done1), .cfg_err(err1), .bl(bl1), .wl(wl1),
        .gfpga_pad_GPIO_PAD(pad1), .outpad(outpad1), .inpad(inpad1)
    );

    task automatic chk(input string nm, input int j,
                       input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%h exp=%h t=%0t", nm, j, got, exp, $time);
        end
    endtask

    // Model: a write is a timeline k=1.. after transfer; SETUP cycles,
    // then the WL pulse, then one hold cycle.
    initial begin
        for (int j = 0; j < 2; j++)
            for (int r = 0; r < 4; r++) msh[j][r] = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            for (int j = 0; j < 2; j++) begin
                bit go;
                if (!rst_n) begin
                    armed[j] = 0; act[j] = 0; mdone[j] = 0; merr[j] = 0; k[j] = 0;
                    for (int r = 0; r < 4; r++) msh[j][r] = '0;
                end else begin
                    go = armed[j] && !act[j] && !mdone[j] && valid[j];
                    armed[j] = 1;
                    if (act[j]) begin
                        if (k[j] == S[j] + 1) msh[j][mr[j]] = md[j];
                        if (k[j] == S[j] + P[j] + 1) begin
                            act[j] = 0;
                            if (ml[j]) mdone[j] = 1;
                        end else begin
                            k[j]++;
                        end
                    end else if (go) begin
                        if (int'(row[j]) < R[j]) begin
                            act[j] = 1; k[j] = 1; mr[j] = int'(row[j]);
                            md[j] = data[j]; ml[j] = last[j];
                        end else begin
                            merr[j] = 1;
                            if (last[j]) mdone[j] = 1;
                        end
                    end
                end
            end
        end
    end

    logic [7:0] pbl [2];
    logic [2:0] pwl [2];

    initial begin
        pbl[0] = '0; pbl[1] = '0; pwl[0] = '0; pwl[1] = '0;
        forever begin
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                logic [7:0] b;
                logic [2:0] w, ew;
                b = j ? bl1 : bl0;
                w = j ? wl1 : {1'b0, wl0};
                ew = (act[j] && k[j] > S[j] && k[j] <= S[j] + P[j]) ?
                     3'(1 << mr[j]) : 3'b000;
                chk("ready", j, 32'(j ? ready1 : ready0),
                    32'(armed[j] && !act[j] && !mdone[j]));
                chk("done", j, 32'(j ? done1 : done0), 32'(mdone[j]));
                chk("err", j, 32'(j ? err1 : err0), 32'(merr[j]));
                chk("bl", j, 32'(b), 32'(act[j] ? md[j] : 8'h00));
                chk("wl", j, 32'(w), 32'(ew));
                chk("wl_onehot", j, 32'($onehot0(w)), 32'd1);
                if (w != 0) chk("bl_stable", j, 32'(b), 32'(pbl[j]));
                pbl[j] = b;
                pwl[j] = w;
            end
            if (!act[0]) begin
                logic [7:0] dir, inv;
                dir = msh[0][0];
                inv = msh[0][1];
                chk("pad", 0, 32'(pad0),
                    32'((dir & (outpad0 ^ inv)) | (~dir & tb_val)));
                chk("inpad", 0, 32'(inpad0), 32'(~dir & tb_val));
            end
        end
    end

    task automatic send(input int j, input int r, input logic [7:0] d, input bit l);
        int n;
        n = 0;
        while ((j ? ready1 : ready0) !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("send_timeout", j, 32'd0, 32'd1);
        #1;
        valid[j] = 1'b1; row[j] = 2'(r); data[j] = d; last[j] = l;
        @(posedge clk);
        #1;
        valid[j] = 1'b0;
    endtask

    task automatic wait_ready(input int j);
        int n;
        n = 0;
        @(negedge clk);
        while ((j ? ready1 : ready0) !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("ready_timeout", j, 32'd0, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        for (int j = 0; j < 2; j++) begin
            valid[j] = 0; row[j] = 0; data[j] = 0; last[j] = 0;
        end
        outpad0 = 8'hFF; outpad1 = 8'h00; tb_val = 8'h3C;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("lit_ready_after_rst", 0, 32'(ready0), 32'd1);
        chk("lit_bl_after_rst", 0, 32'(bl0), 32'd0);
        chk("lit_inpad_rst", 0, 32'(inpad0), 32'h3C);

        #1;
        valid[0] = 1; row[0] = 0; data[0] = 8'hA5; last[0] = 0;
        @(posedge clk);
        #1 valid[0] = 0;
        @(negedge clk);
        chk("lit_c1_bl", 0, 32'(bl0), 32'hA5);
        chk("lit_c1_ready", 0, 32'(ready0), 32'd0);
        chk("lit_c1_wl", 0, 32'(wl0), 32'd0);
        @(negedge clk);
        chk("lit_c2_wl", 0, 32'(wl0), 32'd1);
        @(negedge clk);
        chk("lit_c3_wl", 0, 32'(wl0), 32'd1);
        @(negedge clk);
        chk("lit_c4_wl", 0, 32'(wl0), 32'd0);
        chk("lit_c4_bl", 0, 32'(bl0), 32'hA5);
        @(negedge clk);
        chk("lit_c5_ready", 0, 32'(ready0), 32'd1);
        chk("lit_c5_bl", 0, 32'(bl0), 32'd0);
        chk("lit_pad_a5", 0, 32'(pad0), 32'hBD);
        chk("lit_inpad_a5", 0, 32'(inpad0), 32'h18);

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            #1;
            for (int j = 0; j < 2; j++) begin
                valid[j] = 1'($urandom_range(0, 1));
                row[j] = j ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
                data[j] = 8'($urandom);
                last[j] = 1'b0;
            end
            outpad0 = 8'($urandom);
            outpad1 = 8'($urandom);
            tb_val = 8'($urandom);
        end
        @(negedge clk);
        #1 valid[0] = 0; valid[1] = 0;

        send(0, 1, 8'h5E, 1'b0);
        n = 0;
        @(negedge clk);
        while (wl0 == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("pulse_timeout", 0, 32'd0, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("lit_rst_wl", 0, 32'(wl0), 32'd0);
        chk("lit_rst_bl", 0, 32'(bl0), 32'd0);
        chk("lit_rst_ready", 0, 32'(ready0), 32'd0);
        chk("lit_rst_inpad", 0, 32'(inpad0), 32'(tb_val));
        @(negedge clk);
        #2 rst_n = 1'b1;
        send(0, 0, 8'hC3, 1'b0);
        wait_ready(0);
        chk("lit_rewrite_ready", 0, 32'(ready0), 32'd1);

        send(1, 3, 8'h77, 1'b0);
        @(negedge clk);
        chk("lit_err1", 1, 32'(err1), 32'd1);
        chk("lit_err1_ready", 1, 32'(ready1), 32'd1);
        send(1, 3, 8'h11, 1'b1);
        @(negedge clk);
        chk("lit_err1_done", 1, 32'(done1), 32'd1);

        outpad0 = 8'h00;
        send(0, 0, 8'hFF, 1'b0);
        send(0, 1, 8'h01, 1'b1);
        n = 0;
        @(negedge clk);
        while (done0 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("done_timeout", 0, 32'd0, 32'd1);
        #1 valid[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("lit_done", 0, 32'(done0), 32'd1);
        chk("lit_done_ready", 0, 32'(ready0), 32'd0);
        chk("lit_done_pad", 0, 32'(pad0), 32'h01);
        chk("lit_done_inpad", 0, 32'(inpad0), 32'h00);
        #1 valid[0] = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grid_io_bank_cfg.md
Name: grid_io_bank_cfg

Overview:
Parametrised I/O grid tile with an on-tile memory-bank configuration writer. It accepts row-write transactions over a valid/ready handshake and sequences the BL/WL lines with programmable setup and pulse timing. It keeps a shadow copy of the configuration bits. The shadow direction bit of each subtile controls its GPIO pad, so the tile sits on the fabric periphery and owns both its pads and its configuration programming.

Parameters:
NUM_SUBTILES, 8, number of I/O subtiles; also the BL width (one BL per subtile)
CFG_ROWS, 2, configuration rows per subtile; also the WL width (one WL per row); row 0 = direction, row 1 = output invert
ROW_W, 1, width of cfg_row; must satisfy 2**ROW_W >= CFG_ROWS
SETUP_CYC, 1, cycles BL is stable before WL rises (>=1)
WL_PULSE, 2, cycles WL is held high (>=1)

Ports:
prog_clk  input  1  programming clock; all state on rising edge
pReset_n  input  1  asynchronous active-low reset
cfg_valid  input  1  row-write request
cfg_ready  output  1  writer idle, can accept
cfg_row  input  ROW_W  target row index
cfg_data  input  NUM_SUBTILES  row data, bit i -> subtile i
cfg_last  input  1  final row of the bitstream
cfg_done  output  1  sticky; last row written
cfg_err  output  1  sticky; out-of-range row seen
bl  output  NUM_SUBTILES  bit lines
wl  output  CFG_ROWS  word lines, one-hot or zero
gfpga_pad_GPIO_PAD  inout  NUM_SUBTILES  pads
outpad  input  NUM_SUBTILES  fabric data to pad
inpad  output  NUM_SUBTILES  pad data to fabric

Behaviour:
- Clocking and reset (decided): one clock, prog_clk; reset pReset_n is asynchronous, active-low.
- Reset values: bl=0, wl=0, cfg_ready=0 while pReset_n low; cfg_done=0, cfg_err=0, shadow=0, FSM=IDLE. cfg_ready=1 on the first edge after release.
- Handshake:
  - Transfer occurs on a rising edge with cfg_valid & cfg_ready.
  - cfg_ready is 1 only in IDLE.
  - cfg_row, cfg_data and cfg_last are captured at transfer and are ignored otherwise.
- FSM states: IDLE, SETUP, PULSE, HOLD, DONE.
  - IDLE: on transfer with row<CFG_ROWS, go to SETUP. bl <= captured data, starting the cycle after transfer.
  - IDLE: on transfer with row>=CFG_ROWS, set cfg_err, generate no WL pulse, leave shadow unchanged, stay in IDLE. If cfg_last is also set, go to DONE instead.
  - SETUP: stay SETUP_CYC cycles with wl=0, then go to PULSE.
  - PULSE: wl[row]=1 for exactly WL_PULSE cycles, all other wl=0. On the first PULSE cycle, shadow[row][*] <= data. Then go to HOLD.
  - HOLD: 1 cycle, wl=0, bl still held. Then go to DONE if the captured last was set, else to IDLE with bl <= 0.
  - DONE: cfg_done=1, cfg_ready=0, bl=0, wl=0. Absorbing until reset.
- Latency: a write occupies SETUP_CYC+WL_PULSE+1 cycles after transfer. Back-to-back throughput is one row per SETUP_CYC+WL_PULSE+2 cycles.
- Invariants:
  - WL never rises in the same cycle bl changes.
  - Never more than one WL high.
  - bl only changes on entry to SETUP, or on return to IDLE/DONE.
- Pad datapath (combinational from shadow): dir_i=shadow[0][i], inv_i=shadow[1][i] (inv_i=0 when CFG_ROWS<2).
  - Pad: gfpga_pad_GPIO_PAD[i] = dir_i ? (outpad[i]^inv_i) : Z.
  - Fabric: inpad[i] = dir_i ? 0 : gfpga_pad_GPIO_PAD[i].
- Rewrite: rewriting a row before cfg_last is legal; the latest write wins in the shadow.
- Reset mid-write: wl and bl drop immediately (asynchronously), shadow clears, all pads go Z, cfg_done clears.
- cfg_valid held in a non-IDLE state: no effect; the master must hold it until ready.

Test Plan:
- Reset release, cfg_valid=0 -> bl=0, wl=0, cfg_ready=1 after 1 edge, all pads Z, inpad follows pads.
- Write row0=8'hA5, not last (defaults):
  - cfg_ready drops next cycle; bl=8'hA5 from transfer+1.
  - wl=2'b01 for cycles 2-3; HOLD on cycle 4; ready on cycle 5.
  - Pads 0,2,5,7 drive outpad; inpad[0]=0 and inpad[1]=pad[1].
- Write row1=8'h01, last, after row0=8'hFF, outpad=0 -> wl=2'b10 pulse, cfg_done=1, cfg_ready=0 permanently, pad0=1, pads1-7=0.
- cfg_row=1'b1 with CFG_ROWS=1 build -> cfg_err=1, wl never asserted, shadow unchanged, cfg_ready=1 next cycle.
- pReset_n low during PULSE -> wl=0, bl=0 in the same cycle, pads Z. Re-write succeeds after release.
- SETUP_CYC=3, WL_PULSE=4 build -> wl high exactly 4 cycles starting 4 cycles after transfer; checker confirms one-hot wl and no bl change while wl is high.
